// File: rtl/fir_sample_streamer.sv
// AHB-Lite master feeding a FIR accelerator from a sample stream:
// write sample, poll status until idle, read result, emit it downstream.
module fir_sample_streamer #(
    parameter logic [3:0]  STATUS_ADDR = 4'h0,
    parameter logic [3:0]  RESULT_ADDR = 4'h2,
    parameter logic [3:0]  SAMPLE_ADDR = 4'h4,
    parameter int unsigned MAX_POLLS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        result_valid,
    output logic [15:0] result_data,
    input  logic        result_ready,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp,
    input  logic        hready,
    output logic        err,
    input  logic        clear_err,
    output logic [15:0] sample_count
);

    localparam int unsigned POLL_W       = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_POLL_ADDR,
        S_POLL_DATA,
        S_RES_ADDR,
        S_RES_DATA,
        S_OUT,
        S_ERROR
    } state_t;

    state_t              state, state_next;
    logic [POLL_W-1:0]   poll_cnt, poll_cnt_next;
    logic                sample_ready_next;
    logic                result_valid_next;
    logic [15:0]         result_data_next;
    logic [3:0]          haddr_next;
    logic [1:0]          htrans_next;
    logic                hwrite_next;
    logic [15:0]         hwdata_next;
    logic                err_next;
    logic [15:0]         sample_count_next;

    // Only halfword transfers are ever issued.
    assign hsize = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            poll_cnt     <= '0;
            sample_ready <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            haddr        <= '0;
            htrans       <= HTRANS_IDLE;
            hwrite       <= 1'b0;
            hwdata       <= '0;
            err          <= 1'b0;
            sample_count <= '0;
        end else begin
            state        <= state_next;
            poll_cnt     <= poll_cnt_next;
            sample_ready <= sample_ready_next;
            result_valid <= result_valid_next;
            result_data  <= result_data_next;
            haddr        <= haddr_next;
            htrans       <= htrans_next;
            hwrite       <= hwrite_next;
            hwdata       <= hwdata_next;
            err          <= err_next;
            sample_count <= sample_count_next;
        end
    end

    // Next-state logic; bus and stream outputs are registered decodes of the next state.
    always_comb begin
        state_next        = state;
        poll_cnt_next     = poll_cnt;
        result_data_next  = result_data;
        hwdata_next       = hwdata;
        sample_count_next = sample_count;
        haddr_next        = haddr;

        case (state)
            S_IDLE: begin
                if (sample_ready && sample_valid) begin
                    hwdata_next = sample_data;
                    state_next  = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (hready) state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (hready) begin
                    if (hresp) begin
                        state_next = S_ERROR;
                    end else begin
                        poll_cnt_next = '0;
                        state_next    = S_POLL_ADDR;
                    end
                end
            end
            S_POLL_ADDR: begin
                if (hready) state_next = S_POLL_DATA;
            end
            S_POLL_DATA: begin
                // Bus error outranks anything the status word says.
                if (hready) begin
                    if (hresp || hrdata[8]) begin
                        state_next = S_ERROR;
                    end else if (hrdata[0]) begin
                        if (poll_cnt == POLL_W'(MAX_POLLS - 1)) begin
                            state_next = S_ERROR;
                        end else begin
                            poll_cnt_next = poll_cnt + POLL_W'(1);
                            state_next    = S_POLL_ADDR;
                        end
                    end else begin
                        state_next = S_RES_ADDR;
                    end
                end
            end
            S_RES_ADDR: begin
                if (hready) state_next = S_RES_DATA;
            end
            S_RES_DATA: begin
                if (hready) begin
                    if (hresp) begin
                        state_next = S_ERROR;
                    end else begin
                        result_data_next = hrdata;
                        state_next       = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (result_ready) begin
                    sample_count_next = sample_count + 16'd1;
                    state_next        = S_IDLE;
                end
            end
            S_ERROR: begin
                if (clear_err) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_WR_ADDR:   haddr_next = SAMPLE_ADDR;
            S_POLL_ADDR: haddr_next = STATUS_ADDR;
            S_RES_ADDR:  haddr_next = RESULT_ADDR;
            default:     haddr_next = haddr;
        endcase

        htrans_next = (state_next == S_WR_ADDR || state_next == S_POLL_ADDR ||
                       state_next == S_RES_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite_next       = (state_next == S_WR_ADDR);
        sample_ready_next = (state_next == S_IDLE);
        result_valid_next = (state_next == S_OUT);
        err_next          = (state_next == S_ERROR);
    end

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Bench for fir_sample_streamer: scripted AHB slave, transaction log and a
// list-based model of the expected bus sequence per sample.
module tb_fir_sample_streamer;

    localparam int MAX_POLLS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic        result_valid;
    logic [15:0] result_data;
    logic        result_ready = 1'b1;
    logic [3:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;
    logic        hready = 1'b1;
    logic        err;
    logic        clear_err = 1'b0;
    logic [15:0] sample_count;

    fir_sample_streamer dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
        .haddr(haddr), .hsize(hsize), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hresp(hresp), .hready(hready),
        .err(err), .clear_err(clear_err), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] status_q[$];
    logic [15:0] result_word = '0;
    bit          fail_write = 1'b0;
    bit          rand_wait = 1'b0;
    logic [20:0] bus_log[$];
    logic [20:0] exp_q[$];
    bit          exp_err;
    logic [15:0] exp_count = '0;
    int          overlap_errs = 0;

    // Slave: accepts an address phase on hready, answers in the next hready cycle.
    bit          dp_pending;
    bit          dp_write;
    logic [3:0]  dp_addr;
    logic [15:0] rd_word;
    logic        hresp_r;
    assign hrdata = rd_word;
    assign hresp  = hresp_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_pending <= 1'b0;
            dp_write   <= 1'b0;
            dp_addr    <= '0;
            rd_word    <= '0;
            hresp_r    <= 1'b0;
        end else if (hready) begin
            if (dp_pending) begin
                bus_log.push_back({dp_write, dp_addr, dp_write ? hwdata : rd_word});
                if (htrans != 2'b00) overlap_errs <= overlap_errs + 1;
            end
            dp_pending <= (htrans == 2'b10);
            dp_write   <= hwrite;
            dp_addr    <= haddr;
            hresp_r    <= 1'b0;
            rd_word    <= '0;
            if (htrans == 2'b10) begin
                if (hwrite) hresp_r <= fail_write;
                else if (haddr == 4'h0) rd_word <= (status_q.size() > 0) ? status_q.pop_front() : 16'h0000;
                else if (haddr == 4'h2) rd_word <= result_word;
            end
        end
    end

    always @(negedge clk) hready <= rand_wait ? ($urandom_range(0, 3) != 0) : 1'b1;

    // Expected transfers: one write, status reads until idle/error/timeout, then a result read.
    task automatic build_expected(input logic [15:0] smp, input logic [15:0] script[$]);
        logic [15:0] word;
        bit done = 1'b0;
        int i = 0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_q.push_back({1'b1, 4'h4, smp});
        while (!done) begin
            word = (i < script.size()) ? script[i] : 16'h0000;
            exp_q.push_back({1'b0, 4'h0, 16'h0000});
            if (word[8]) begin exp_err = 1'b1; done = 1'b1; end
            else if (word[0]) begin
                if (i == MAX_POLLS - 1) begin exp_err = 1'b1; done = 1'b1; end
                else i++;
            end else done = 1'b1;
        end
        if (!exp_err) exp_q.push_back({1'b0, 4'h2, 16'h0000});
    endtask

    function automatic int first_diff();
        int n;
        logic [20:0] m;
        n = (bus_log.size() < exp_q.size()) ? bus_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            m = exp_q[i][20] ? 21'h1FFFFF : 21'h1F0000;
            if ((bus_log[i] & m) !== exp_q[i]) return i;
        end
        if (bus_log.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [20:0] log_at(input int i);
        return (i >= 0 && i < bus_log.size()) ? bus_log[i] : 21'h0;
    endfunction

    function automatic logic [20:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 21'h0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        status_q.delete();
        fail_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_count = '0;
        bus_log.delete();
    endtask

    task automatic send_sample(input logic [15:0] d);
        int n = 0;
        sample_data  = d;
        sample_valid = 1'b1;
        while (!sample_ready && n < 400) begin @(negedge clk); n++; end
        vectors++;
        if (!sample_ready) begin
            miscompares++;
            $display("FAIL sample_accept: sample_ready=%b after %0d cycles, want 1", sample_ready, n);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic get_result(input bit rnd, output logic [15:0] d, output bit ok);
        int n = 0;
        ok = 1'b0;
        d  = '0;
        while (!ok && n < 600) begin
            result_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            clear_err    = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (result_valid && result_ready) begin d = result_data; ok = 1'b1; end
            @(negedge clk);
            n++;
        end
        result_ready = 1'b1;
        clear_err    = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL result_timeout: result_valid=%b after %0d cycles, want 1", result_valid, n);
        end
    endtask

    task automatic wait_err();
        int n = 0;
        while (!err && n < 400) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        logic [58:0] want;
        rst = 1'b1;
        @(negedge clk);
        want = {2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
        vectors++;
        if ({htrans, haddr, hwrite, hwdata, hsize, sample_ready, result_valid, result_data, err, sample_count} !== want) begin
            miscompares++;
            $display("FAIL reset_values: got %h, want %h", {htrans, haddr, hwrite, hwdata, hsize, sample_ready,
                     result_valid, result_data, err, sample_count}, want);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({sample_ready, htrans} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release: {sample_ready,htrans}=%b, want 100", {sample_ready, htrans});
        end
    endtask

    task automatic test_single();
        logic [15:0] script[$];
        logic [15:0] d;
        bit ok;
        int idx;
        do_reset();
        script = {16'h0000};
        status_q = script;
        result_word = 16'h0040;
        send_sample(16'h0100);
        get_result(1'b0, d, ok);
        exp_count++;
        vectors++;
        if (d !== 16'h0040) begin miscompares++; $display("FAIL single_result: got %h, want 0040", d); end
        vectors++;
        if (sample_count !== exp_count) begin
            miscompares++; $display("FAIL single_count: got %0d, want %0d", sample_count, exp_count);
        end
        build_expected(16'h0100, script);
        idx = first_diff();
        vectors++;
        if (idx >= 0) begin
            miscompares++;
            $display("FAIL single_bus: txn %0d got %h want %h (%0d vs %0d txns)", idx, log_at(idx), exp_at(idx),
                     bus_log.size(), exp_q.size());
        end
    endtask

    task automatic test_busy_polls();
        logic [15:0] script[$];
        logic [15:0] d;
        bit ok;
        int idx;
        bus_log.delete();
        script = {16'h0001, 16'h0001, 16'h0001, 16'h0000};
        status_q = script;
        result_word = 16'h7FFF;
        send_sample(16'h8000);
        get_result(1'b0, d, ok);
        exp_count++;
        vectors++;
        if ({err, d} !== {1'b0, 16'h7FFF}) begin
            miscompares++; $display("FAIL busy_result: err/result got %h, want 07fff", {err, d});
        end
        build_expected(16'h8000, script);
        idx = first_diff();
        vectors++;
        if (idx >= 0) begin
            miscompares++;
            $display("FAIL busy_bus: txn %0d got %h want %h (%0d vs %0d txns)", idx, log_at(idx), exp_at(idx),
                     bus_log.size(), exp_q.size());
        end
    endtask

    // Shared tail of the error scenarios: stay parked, then leave via clear_err.
    task automatic run_error_case(input string name, input logic [15:0] smp, input logic [15:0] script[$],
                                  input bit wr_fail);
        int idx;
        bus_log.delete();
        status_q = script;
        fail_write = wr_fail;
        send_sample(smp);
        wait_err();
        repeat (4) @(negedge clk);
        build_expected(smp, script);
        if (wr_fail) begin exp_q = {exp_q[0]}; exp_err = 1'b1; end
        vectors++;
        if ({err, htrans, sample_ready, result_valid} !== {exp_err, 2'b00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_state: {err,htrans,sready,rvalid}=%b, want %b", name,
                     {err, htrans, sample_ready, result_valid}, {exp_err, 2'b00, 1'b0, 1'b0});
        end
        idx = first_diff();
        vectors++;
        if (idx >= 0) begin
            miscompares++;
            $display("FAIL %s_bus: txn %0d got %h want %h (%0d vs %0d txns)", name, idx, log_at(idx), exp_at(idx),
                     bus_log.size(), exp_q.size());
        end
        fail_write = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        vectors++;
        if ({err, sample_ready, sample_count} !== {1'b0, 1'b1, exp_count}) begin
            miscompares++;
            $display("FAIL %s_clear: {err,sready,count}=%h, want %h", name, {err, sample_ready, sample_count},
                     {1'b0, 1'b1, exp_count});
        end
    endtask

    task automatic test_errors();
        logic [15:0] script[$];
        script.delete();
        for (int i = 0; i < 20; i++) script.push_back(16'h0001);
        run_error_case("timeout", 16'h1111, script, 1'b0);
        script = {16'h0100};
        run_error_case("status_err", 16'h2222, script, 1'b0);
        script = {16'h0000};
        run_error_case("write_hresp", 16'h3333, script, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] script[$];
        bit ok;
        int n = 0;
        int idx;
        status_q.delete();
        result_word = 16'h1234;
        result_ready = 1'b0;
        send_sample(16'hA5A5);
        while (!result_valid && n < 400) begin @(negedge clk); n++; end
        sample_data  = 16'h5A5A;
        sample_valid = 1'b1;
        result_word  = 16'h5678;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({result_valid, result_data, sample_ready} !== {1'b1, 16'h1234, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_%0d: {rvalid,rdata,sready}=%h, want %h", i,
                         {result_valid, result_data, sample_ready}, {1'b1, 16'h1234, 1'b0});
            end
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        bus_log.delete();
        vectors++;
        if ({result_valid, sample_ready, sample_count} !== {1'b0, 1'b1, exp_count}) begin
            miscompares++;
            $display("FAIL release: {rvalid,sready,count}=%h, want %h", {result_valid, sample_ready, sample_count},
                     {1'b0, 1'b1, exp_count});
        end
        @(negedge clk);
        sample_valid = 1'b0;
        vectors++;
        if ({sample_ready, htrans, haddr, hwdata} !== {1'b0, 2'b10, 4'h4, 16'h5A5A}) begin
            miscompares++;
            $display("FAIL next_accept: {sready,htrans,haddr,hwdata}=%h, want %h", {sample_ready, htrans, haddr, hwdata},
                     {1'b0, 2'b10, 4'h4, 16'h5A5A});
        end
        get_result(1'b0, d, ok);
        exp_count++;
        vectors++;
        if (d !== 16'h5678) begin miscompares++; $display("FAIL second_result: got %h, want 5678", d); end
        script.delete();
        build_expected(16'h5A5A, script);
        idx = first_diff();
        vectors++;
        if (idx >= 0) begin
            miscompares++;
            $display("FAIL second_bus: txn %0d got %h want %h (%0d vs %0d txns)", idx, log_at(idx), exp_at(idx),
                     bus_log.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [58:0] want;
        logic [15:0] d;
        bit ok;
        int n = 0;
        status_q.delete();
        for (int i = 0; i < 10; i++) status_q.push_back(16'h0001);
        result_word = 16'hBEEF;
        send_sample(16'h2222);
        while (!(dp_pending && !dp_write && dp_addr == 4'h0) && n < 400) begin @(negedge clk); n++; end
        vectors++;
        if (!dp_pending) begin miscompares++; $display("FAIL poll_reach: no status data phase after %0d cycles", n); end
        #2 rst = 1'b1;
        #1;
        want = {2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0};
        vectors++;
        if ({htrans, haddr, hwrite, hwdata, hsize, sample_ready, result_valid, result_data, err, sample_count} !== want) begin
            miscompares++;
            $display("FAIL async_reset: got %h, want %h", {htrans, haddr, hwrite, hwdata, hsize, sample_ready,
                     result_valid, result_data, err, sample_count}, want);
        end
        @(negedge clk);
        rst = 1'b0;
        status_q.delete();
        exp_count = '0;
        @(negedge clk);
        bus_log.delete();
        send_sample(16'h3333);
        get_result(1'b0, d, ok);
        exp_count++;
        vectors++;
        if ({d, sample_count} !== {16'hBEEF, exp_count}) begin
            miscompares++; $display("FAIL after_reset: {result,count}=%h, want %h", {d, sample_count}, {16'hBEEF, exp_count});
        end
    endtask

    task automatic test_random();
        logic [15:0] script[$];
        logic [15:0] d, smp, rw;
        bit ok;
        int idx, nb;
        rand_wait = 1'b1;
        for (int s = 0; s < 30; s++) begin
            script.delete();
            nb = $urandom_range(0, 5);
            for (int k = 0; k < nb; k++) script.push_back((16'($urandom) & 16'hFEFE) | 16'h0001);
            script.push_back(16'($urandom) & 16'hFEFE);
            status_q = script;
            rw  = 16'($urandom);
            smp = 16'($urandom);
            result_word = rw;
            bus_log.delete();
            send_sample(smp);
            get_result(1'b1, d, ok);
            exp_count++;
            vectors++;
            if (d !== rw) begin miscompares++; $display("FAIL rand_result_%0d: got %h, want %h", s, d, rw); end
            build_expected(smp, script);
            idx = first_diff();
            vectors++;
            if (idx >= 0) begin
                miscompares++;
                $display("FAIL rand_bus_%0d: txn %0d got %h want %h (%0d vs %0d txns)", s, idx, log_at(idx),
                         exp_at(idx), bus_log.size(), exp_q.size());
            end
        end
        rand_wait = 1'b0;
        @(negedge clk);
        vectors++;
        if ({err, sample_count} !== {1'b0, exp_count}) begin
            miscompares++; $display("FAIL rand_count: {err,count}=%h, want %h", {err, sample_count}, {1'b0, exp_count});
        end
        vectors++;
        if (overlap_errs != 0) begin
            miscompares++; $display("FAIL no_overlap: %0d address phases during data phases, want 0", overlap_errs);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_busy_polls();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
